// File: rtl/elevator_request_scheduler.sv
// LOOK-policy floor scheduler (SCHED_NEAREST_EN selects nearest-floor policy); call->target_valid in 3 cycles,
// target held on target_floor until target_ready; calls keep accumulating while the handshake is stalled.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4,
    parameter int DOOR_HOLD  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  arrived,
    input  logic                  sensor,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    input  logic                  target_ready,
    output logic                  direction,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DOOR_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(DOOR_HOLD - 1);

    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, MOVING, DOOR} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      dwell, dwell_nxt;
    logic [FLOOR_W-1:0]    target_nxt;
    logic                  dir_nxt, valid_nxt, door_nxt;
    logic [NUM_FLOORS-1:0] clear_mask, pending_nxt;
    logic                  arrive_hit;

    logic                  up_found, dn_found, sel_found, sel_dir;
    logic [FLOOR_W-1:0]    up_floor, dn_floor, sel_floor;

    assign arrive_hit = (state == MOVING) && arrived && (current_floor == target_floor);
    assign busy       = (state != IDLE);

    // Nearest pending floor strictly above and strictly below the car.
    always_comb begin
        up_found = 1'b0;
        up_floor = '0;
        dn_found = 1'b0;
        dn_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(current_floor))) begin
                up_found = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(current_floor))) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
    end

`ifdef SCHED_NEAREST_EN
    logic [FLOOR_W-1:0] up_dist, dn_dist;
    assign up_dist = up_floor - current_floor;
    assign dn_dist = current_floor - dn_floor;

    always_comb begin
        sel_floor = '0;
        sel_dir   = direction;
        if (up_found && (!dn_found || (up_dist <= dn_dist))) begin
            sel_floor = up_floor;
            sel_dir   = 1'b1;
        end else if (dn_found) begin
            sel_floor = dn_floor;
            sel_dir   = 1'b0;
        end
    end
`else
    // Keep sweeping the current direction; reverse only when that side is empty.
    always_comb begin
        sel_floor = '0;
        sel_dir   = direction;
        if (direction) begin
            if (up_found) begin
                sel_floor = up_floor;
                sel_dir   = 1'b1;
            end else if (dn_found) begin
                sel_floor = dn_floor;
                sel_dir   = 1'b0;
            end
        end else begin
            if (dn_found) begin
                sel_floor = dn_floor;
                sel_dir   = 1'b0;
            end else if (up_found) begin
                sel_floor = up_floor;
                sel_dir   = 1'b1;
            end
        end
    end
`endif

    assign sel_found = up_found | dn_found;

    // The serviced floor is masked for the whole dwell so repeat presses are absorbed.
    always_comb begin
        clear_mask = '0;
        if (arrive_hit) begin
            clear_mask[target_floor] = 1'b1;
        end
        if (state == DOOR) begin
            clear_mask[current_floor] = 1'b1;
        end
        pending_nxt = (pending | call_req) & ~clear_mask;
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target_floor;
        dir_nxt    = direction;
        valid_nxt  = target_valid;
        door_nxt   = door_open;
        dwell_nxt  = dwell;
        case (state)
            IDLE: begin
                if (|pending) begin
                    if (pending[current_floor]) begin
                        target_nxt = current_floor;
                        door_nxt   = 1'b1;
                        dwell_nxt  = HOLD_LOAD;
                        state_nxt  = DOOR;
                    end else begin
                        state_nxt  = SELECT;
                    end
                end
            end
            SELECT: begin
                if (sel_found) begin
                    target_nxt = sel_floor;
                    dir_nxt    = sel_dir;
                    valid_nxt  = 1'b1;
                    state_nxt  = ISSUE;
                end else begin
                    state_nxt  = IDLE;
                end
            end
            ISSUE: begin
                if (target_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = MOVING;
                end
            end
            MOVING: begin
                if (arrive_hit) begin
                    door_nxt  = 1'b1;
                    dwell_nxt = HOLD_LOAD;
                    state_nxt = DOOR;
                end
            end
            DOOR: begin
                if (sensor) begin
                    dwell_nxt = HOLD_LOAD;
                end else if (dwell == '0) begin
                    door_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    dwell_nxt = dwell - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pending      <= '0;
            target_floor <= '0;
            target_valid <= 1'b0;
            direction    <= 1'b1;
            door_open    <= 1'b0;
            dwell        <= '0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            target_floor <= target_nxt;
            target_valid <= valid_nxt;
            direction    <= dir_nxt;
            door_open    <= door_nxt;
            dwell        <= dwell_nxt;
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios plus random traffic against a call-level model.
module tb_elevator_request_scheduler;

    localparam int NF = 16;
    localparam int FW = 4;
    localparam int DH = 8;

    localparam int P_IDLE   = 0;
    localparam int P_SELECT = 1;
    localparam int P_ISSUE  = 2;
    localparam int P_MOVING = 3;
    localparam int P_DOOR   = 4;

    logic          clk;
    logic          rst_n;
    logic [NF-1:0] call_req;
    logic [FW-1:0] current_floor;
    logic          arrived;
    logic          sensor;
    logic [FW-1:0] target_floor;
    logic          target_valid;
    logic          target_ready;
    logic          direction;
    logic          door_open;
    logic [NF-1:0] pending;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Reference model state: phase of service, outstanding calls, chosen floor, sweep, door cycles left.
    int            m_phase;
    logic [NF-1:0] m_pend;
    logic [FW-1:0] m_target;
    logic          m_dir;
    int            m_left;
    int            mv_wait;

    elevator_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DOOR_HOLD(DH)) dut (
        .clk(clk), .rst_n(rst_n), .call_req(call_req), .current_floor(current_floor),
        .arrived(arrived), .sensor(sensor), .target_floor(target_floor),
        .target_valid(target_valid), .target_ready(target_ready), .direction(direction),
        .door_open(door_open), .pending(pending), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void choose(input logic [NF-1:0] p, input int cf, input logic dir,
                                   output logic ok, output int t, output logic nd);
        int up;
        int dn;
        ok = 1'b0; t = 0; nd = dir;
`ifdef SCHED_NEAREST_EN
        up = 0; dn = 0;
        for (int d = 1; d < NF && !ok; d++) begin
            if (cf + d < NF && p[cf + d]) begin
                ok = 1'b1; t = cf + d; nd = 1'b1;
            end else if (cf - d >= 0 && p[cf - d]) begin
                ok = 1'b1; t = cf - d; nd = 1'b0;
            end
        end
`else
        up = -1; dn = -1;
        for (int f = 0; f < NF; f++) begin
            if (p[f] && f > cf && up < 0) up = f;
            if (p[f] && f < cf) dn = f;
        end
        if (dir && up >= 0)       begin ok = 1'b1; t = up; nd = 1'b1; end
        else if (dn >= 0)         begin ok = 1'b1; t = dn; nd = 1'b0; end
        else if (up >= 0)         begin ok = 1'b1; t = up; nd = 1'b1; end
`endif
    endfunction

    always @(posedge clk) begin : model
        logic [NF-1:0] np;
        int   nph;
        logic [FW-1:0] nt;
        logic nd;
        int   nleft;
        logic ok;
        int   pick;
        np = m_pend | call_req; nph = m_phase; nt = m_target; nd = m_dir; nleft = m_left;
        if (!rst_n) begin
            np = '0; nph = P_IDLE; nt = '0; nd = 1'b1; nleft = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (m_pend != '0) begin
                    if (m_pend[current_floor]) begin
                        nt = current_floor; nph = P_DOOR; nleft = DH;
                    end else nph = P_SELECT;
                end
                P_SELECT: begin
                    choose(m_pend, int'(current_floor), m_dir, ok, pick, nd);
                    if (ok) begin nt = FW'(pick); nph = P_ISSUE; end
                    else nph = P_IDLE;
                end
                P_ISSUE: if (target_ready) nph = P_MOVING;
                P_MOVING: if (arrived && current_floor == m_target) begin
                    np[m_target] = 1'b0; nph = P_DOOR; nleft = DH;
                end
                default: begin
                    np[current_floor] = 1'b0;
                    if (sensor) nleft = DH;
                    else if (m_left == 1) nph = P_IDLE;
                    else nleft = m_left - 1;
                end
            endcase
        end
        m_pend   <= np;
        m_phase  <= nph;
        m_target <= nt;
        m_dir    <= nd;
        m_left   <= nleft;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({target_floor, target_valid, direction, door_open, pending, busy} !==
                {m_target, (m_phase == P_ISSUE), m_dir, (m_phase == P_DOOR), m_pend, (m_phase != P_IDLE)}) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got tgt=%0d vld=%b dir=%b door=%b pend=%h busy=%b, expected tgt=%0d vld=%b dir=%b door=%b pend=%h busy=%b",
                         $time, target_floor, target_valid, direction, door_open, pending, busy,
                         m_target, (m_phase == P_ISSUE), m_dir, (m_phase == P_DOOR), m_pend, (m_phase != P_IDLE));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Acts as the motion unit: accept the next target, drive the car there and report arrival.
    task automatic serve(output int tgt, output logic dir_at_issue);
        int n;
        n = 0;
        while (!target_valid && n < 50) begin tick; n++; end
        chk("issue_timeout", {31'd0, target_valid}, 1);
        tgt = int'(target_floor);
        dir_at_issue = direction;
        target_ready = 1'b1; tick; target_ready = 1'b0;
        current_floor = FW'(tgt); arrived = 1'b1; tick; arrived = 1'b0;
        n = 0;
        while (busy && n < 100) begin tick; n++; end
        chk("serve_timeout", {31'd0, busy}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1, t2, t3, k, after, cnt, r;
        logic d1, d2, d3;
        logic [NF-1:0] one;
        one = 1;
        rst_n = 1'b0; call_req = '1; current_floor = '0; arrived = 1'b0; sensor = 1'b0;
        target_ready = 1'b0; mv_wait = 0;
        m_phase = P_IDLE; m_pend = '0; m_target = '0; m_dir = 1'b1; m_left = 0;

        // Reset holds everything clear even with every call asserted.
        tick; chk_en = 1'b1; tick;
        chk("rst_pending", 32'(pending), 0);
        chk("rst_valid", {31'd0, target_valid}, 0);
        chk("rst_door", {31'd0, door_open}, 0);
        chk("rst_dir", {31'd0, direction}, 1);
        call_req = '0; rst_n = 1'b1; tick;
        chk("rst_idle", {31'd0, busy}, 0);

        // Single call for floor 3 from floor 0.
        call_req = one << 3; tick; call_req = '0;
        chk("call_latched", 32'(pending), 32'h8);
        tick;
        chk("select_no_valid", {31'd0, target_valid}, 0);
        tick;
        chk("valid_cycle3", {31'd0, target_valid}, 1);
        chk("target_3", 32'(target_floor), 3);
        repeat (5) tick;
        chk("held_target", 32'(target_floor), 3);
        chk("held_valid", {31'd0, target_valid}, 1);
        target_ready = 1'b1; tick; target_ready = 1'b0;
        chk("moving_valid_low", {31'd0, target_valid}, 0);
        chk("moving_busy", {31'd0, busy}, 1);
        current_floor = 4'd3; arrived = 1'b1; tick; arrived = 1'b0;
        cnt = 0;
        while (door_open && cnt < 50) begin cnt++; tick; end
        chk("door_cycles", cnt, DH);
        chk("pending3_clear", {31'd0, pending[3]}, 0);
        chk("back_idle", {31'd0, busy}, 0);

        // Sweep ordering from floor 5 going up with calls {2,7,9}.
        current_floor = 4'd5; tick;
        call_req = (one << 2) | (one << 7) | (one << 9); tick; call_req = '0;
        serve(t1, d1); serve(t2, d2); serve(t3, d3);
        chk("order_1", t1, 7);
        chk("order_2", t2, 9);
        chk("order_3", t3, 2);
        chk("dir_before_2", {31'd0, d3}, 0);

        // Car back at 5 heading down with calls {3,7}.
        current_floor = 4'd5; tick;
        call_req = (one << 3) | (one << 7); tick; call_req = '0;
        serve(t1, d1); serve(t2, d2);
`ifdef SCHED_NEAREST_EN
        chk("tie_first", t1, 7);
        chk("tie_second", t2, 3);
`else
        chk("down_first", t1, 3);
        chk("down_second", t2, 7);
`endif

        // Door obstruction mid-dwell and a repeat call for the open floor.
        call_req = one << 1; tick; call_req = '0;
        k = 0;
        while (!target_valid && k < 50) begin tick; k++; end
        target_ready = 1'b1; tick; target_ready = 1'b0;
        current_floor = 4'd1; arrived = 1'b1; tick; arrived = 1'b0;
        k = 1; after = 0;
        while (door_open && k < 100) begin
            sensor = (k >= 5 && k <= 7);
            call_req = (k == 2) ? (one << 1) : '0;
            if (k >= 8) after++;
            tick; k++;
        end
        sensor = 1'b0; call_req = '0;
        chk("door_after_sensor", after, DH);
        chk("dwell_call_absorbed", {31'd0, pending[1]}, 0);

        // Wrong-floor arrival, then reset during the move.
        call_req = one << 6; tick; call_req = '0;
        k = 0;
        while (!target_valid && k < 50) begin tick; k++; end
        chk("target_6", 32'(target_floor), 6);
        target_ready = 1'b1; tick; target_ready = 1'b0;
        call_req = one << 9; current_floor = 4'd4; arrived = 1'b1; tick;
        arrived = 1'b0; call_req = '0; tick;
        chk("mismatch_busy", {31'd0, busy}, 1);
        chk("mismatch_door", {31'd0, door_open}, 0);
        rst_n = 1'b0; tick; rst_n = 1'b1;
        chk("midmove_rst_pending", 32'(pending), 0);
        chk("midmove_rst_valid", {31'd0, target_valid}, 0);
        chk("midmove_rst_idle", {31'd0, busy}, 0);

        // Random traffic with a motion unit that follows the model's accepted target.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            arrived = 1'b0;
            r = int'($urandom_range(0, 9));
            if (r == 0) call_req = NF'($urandom);
            else if (r < 3) call_req = one << $urandom_range(0, NF - 1);
            else call_req = '0;
            target_ready = ($urandom_range(0, 2) == 0);
            sensor = (m_phase == P_DOOR) && ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
            if (m_phase == P_MOVING) begin
                if (mv_wait > 0) mv_wait--;
                else if (current_floor != m_target) begin
                    if ($urandom_range(0, 5) == 0) arrived = 1'b1;
                    else begin
                        current_floor = (current_floor < m_target) ? current_floor + 4'd1 : current_floor - 4'd1;
                        mv_wait = int'($urandom_range(0, 2));
                    end
                end else arrived = 1'b1;
            end
            tick;
        end
        call_req = '0; arrived = 1'b0; sensor = 1'b0; target_ready = 1'b0; rst_n = 1'b1;
        repeat (3) tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
